game_dumper: RTL and testbench
==============================

# game_dumper

Streams a loaded game back out of cartridge memory as an iNES byte stream: a 16-byte header rebuilt from bank counts and mapper bits, then PRG, then CHR. It is the transmit-side counterpart of the iNES loader and reads the same memory map, PRG at 0x000000 and CHR at 0x200000. It feeds a byte-wide valid/ready sink, such as a UART or host FIFO, for save/verify dumps.

## Interface
Parameters:
- ADDR_W, 22, memory byte-address width.
- CHR_BASE, 22'h200000, first CHR byte address.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE/DONE/ERROR.
- prg_banks  in  8  PRG size in 16 KiB units, sampled at start.
- chr_banks  in  8  CHR size in 8 KiB units (0 = CHR RAM, no CHR bytes), sampled at start.
- mapper  in  8  iNES mapper number, sampled at start.
- mirroring  in  1  header flags6 bit 0, sampled at start.
- mem_addr  out  ADDR_W  read address, valid while mem_rd.
- mem_rd  out  1  one-cycle read strobe.
- mem_ack  in  1  read data valid; arrives ≥1 cycle after mem_rd.
- mem_data  in  8  read data, qualified by mem_ack.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready.
- busy  out  1  stream in progress.
- done  out  1  last byte accepted; held until next start/reset.
- error  out  1  invalid size request; held until next start/reset.

## Operation
- States: IDLE, HDR, RD_REQ, RD_WAIT, SEND, DONE, ERROR.
- Accepting start:
  - Latches the inputs.
  - Clears done and error.
  - Loads the byte counter.
- Size check: prg_banks > 128 (would overrun CHR_BASE) goes to ERROR. No mem_rd and no out_valid are issued.
- HDR state: emits 16 bytes, in order:
  - 4E 45 53 1A (the "NES\x1A" magic);
  - prg_banks, chr_banks;
  - flags6 = {mapper[3:0], 3'b000, mirroring};
  - flags7 = {mapper[7:4], 4'b0000};
  - eight 00 bytes.
  - Trainer and four-screen bits are always 0.
- PRG phase:
  - Transfers prg_banks×16384 bytes from address 0 upward.
  - Each byte is a strict sequence: RD_REQ pulses mem_rd at mem_addr → RD_WAIT until mem_ack, which captures mem_data into out_data → SEND holds out_valid until accepted → address increments.
  - Exactly one read is outstanding at a time.
- CHR phase: same procedure, chr_banks×8192 bytes from CHR_BASE upward. Skipped entirely when chr_banks == 0.
- Zero-length phases are skipped. prg_banks = 0 with chr_banks = 0 yields the header only.
- After the final accepted byte: DONE, done=1, busy=0.
- Address and length arithmetic:
  - Byte counter is 22 bits: {prg_banks, 14'b0} or {1'b0, chr_banks, 13'b0}.
  - The phase ends when the counter reaches 0 after a transfer.
  - mem_addr never wraps.
- Ignored inputs:
  - start while busy.
  - mem_ack outside RD_WAIT.
  - out_ready without out_valid.

## Timing
- Reset values: every output is 0, state is IDLE.
- start in cycle N → busy=1 and out_valid=1 with byte 4E in cycle N+1.
- Header: one byte per cycle while out_ready is held high.
- Memory bytes: mem_rd in the cycle after the previous transfer (or after the last header byte) → out_valid in the cycle after mem_ack.
  - Best case: 3 cycles per byte.
- out_data is stable while out_valid && !out_ready.
- Error: start with a bad size → error=1 in N+1, busy stays 0.
- Reset mid-stream: all outputs return to 0 the next cycle. Any in-flight mem_ack is ignored.

## Configuration
- GAME_DUMPER_CRC_EN defined:
  - After the payload, append 4 bytes of CRC-32 (IEEE reflected, init FFFFFFFF, final xor FFFFFFFF), least significant byte first.
  - Coverage is every PRG and CHR byte, not the header.
  - State CRC is inserted between the last payload byte and DONE.
- Undefined: no CRC logic; the stream ends after the last CHR (or PRG) byte.

## Structure
- Shared package nes_loader_pkg:
  - INES_MAGIC bytes;
  - INES_HDR_LEN = 16;
  - PRG_BANK_SHIFT = 14, CHR_BANK_SHIFT = 13;
  - CHR_BASE;
  - MAX_PRG_BANKS = 128;
  - the state enum.
- Sub-module crc32_byte (present only under the macro):
  - per-byte CRC register with clear/update enables;
  - combinational next-value from {crc, byte}.

## Test plan
- prg=1, chr=1, mapper=0, mirroring=1, ready always high, mem_ack 1 cycle after mem_rd:
  - header is 4E 45 53 1A 01 01 01 00 + 8×00;
  - reads cover 0x000000–0x003FFF, then 0x200000–0x201FFF;
  - 24592 bytes total, then done=1.
- prg=2, chr=0, mapper=0x42:
  - flags6 = 0x20, flags7 = 0x40;
  - no address ≥ 0x200000 is read;
  - 32784 bytes total.
- Backpressure: out_ready low for 5 cycles at PRG byte 100 → out_data and mem_addr stable, no mem_rd, byte 100 emitted once.
- prg=129 → error=1 next cycle, out_valid and mem_rd never asserted; a later start with prg=1 clears error.
- Reset asserted during a PRG RD_WAIT → next cycle every output is 0; a late mem_ack causes no output.
- With GAME_DUMPER_CRC_EN:
  - prg=0, chr=0 → 16 header bytes then 00 00 00 00;
  - prg=1 with memory = address[7:0] → trailing 4 bytes match the bench CRC-32 model.

Source files
------------

// File: rtl/nes_loader_pkg.sv
// Shared iNES constants, dumper state encoding and header byte builder.
// GAME_DUMPER_CRC_EN adds the CRC trailer state.
package nes_loader_pkg;

  localparam logic [31:0] INES_MAGIC     = 32'h4E45531A;  // "NES\x1A"
  localparam int          INES_HDR_LEN   = 16;
  localparam int          PRG_BANK_SHIFT = 14;            // 16 KiB banks
  localparam int          CHR_BANK_SHIFT = 13;            // 8 KiB banks
  localparam logic [21:0] CHR_BASE       = 22'h200000;
  localparam logic [7:0]  MAX_PRG_BANKS  = 8'd128;        // more would run into CHR
  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;  // reflected IEEE polynomial
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SEND,
    ST_DONE,
    ST_ERROR
`ifdef GAME_DUMPER_CRC_EN
    , ST_CRC
`endif
  } state_t;

  // Header byte at position idx; trainer and four-screen bits stay clear.
  function automatic logic [7:0] ines_hdr_byte(input logic [3:0] idx,
                                               input logic [7:0] prg,
                                               input logic [7:0] chr,
                                               input logic [7:0] mapper,
                                               input logic       mirroring);
    logic [7:0] b;
    case (idx)
      4'd0:    b = INES_MAGIC[31:24];
      4'd1:    b = INES_MAGIC[23:16];
      4'd2:    b = INES_MAGIC[15:8];
      4'd3:    b = INES_MAGIC[7:0];
      4'd4:    b = prg;
      4'd5:    b = chr;
      4'd6:    b = {mapper[3:0], 3'b000, mirroring};
      4'd7:    b = {mapper[7:4], 4'b0000};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/game_dumper_if.sv
// Memory read port plus byte-stream output of the game dumper.
interface game_dumper_if #(
  parameter int ADDR_W = 22
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd, out_data, out_valid,
    input  mem_ack, mem_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_data, out_valid,
    output mem_ack, mem_data, out_ready
  );
endinterface

// File: rtl/game_dumper_crc32.sv
// Byte-serial CRC-32 (reflected IEEE) register; only built with GAME_DUMPER_CRC_EN.
`ifdef GAME_DUMPER_CRC_EN
module crc32_byte
  import nes_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        upd,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Next CRC value if the current byte is folded in.
  always_comb begin
    crc_next = crc32_step(crc_reg, data);
  end

  // CRC register: restart on clear, absorb one byte per update.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      crc_reg <= CRC32_INIT;
    end else if (upd) begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule
`endif

// File: rtl/game_dumper.sv
// Streams a loaded game as iNES: rebuilt 16-byte header, PRG bytes, CHR bytes.
// One memory read is outstanding at a time. GAME_DUMPER_CRC_EN appends a CRC-32
// of the payload, least significant byte first.
module game_dumper #(
  parameter int                ADDR_W   = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE = nes_loader_pkg::CHR_BASE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    prg_banks,
  input  logic [7:0]    chr_banks,
  input  logic [7:0]    mapper,
  input  logic          mirroring,
  game_dumper_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          error
);
  import nes_loader_pkg::*;

  state_t            state_reg, state_next;
  logic [3:0]        hdr_idx_reg, hdr_idx_next;
  logic [7:0]        prg_reg, prg_next;
  logic [7:0]        chr_reg, chr_next;
  logic [7:0]        mapper_reg, mapper_next;
  logic              mirror_reg, mirror_next;
  logic              chr_phase_reg, chr_phase_next;
  logic [21:0]       cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic              out_valid_c;
  logic [7:0]        out_data_c;

`ifdef GAME_DUMPER_CRC_EN
  localparam state_t TAIL_STATE = ST_CRC;
  logic [1:0]  crc_idx_reg, crc_idx_next;
  logic [31:0] crc_val;
  logic [31:0] crc_final;
  logic        start_accept;

  assign start_accept = start && (state_reg inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign crc_final    = ~crc_val;

  crc32_byte u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (start_accept),
    .upd   ((state_reg == ST_SEND) && bus.out_ready),
    .data  (data_reg),
    .crc   (crc_val)
  );
`else
  localparam state_t TAIL_STATE = ST_DONE;
`endif

  // Next-state and datapath updates for the header / read / send sequence.
  always_comb begin
    state_next     = state_reg;
    hdr_idx_next   = hdr_idx_reg;
    prg_next       = prg_reg;
    chr_next       = chr_reg;
    mapper_next    = mapper_reg;
    mirror_next    = mirror_reg;
    chr_phase_next = chr_phase_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
`ifdef GAME_DUMPER_CRC_EN
    crc_idx_next   = crc_idx_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          prg_next       = prg_banks;
          chr_next       = chr_banks;
          mapper_next    = mapper;
          mirror_next    = mirroring;
          hdr_idx_next   = '0;
          chr_phase_next = 1'b0;
          addr_next      = '0;
          cnt_next       = 22'(prg_banks) << PRG_BANK_SHIFT;
`ifdef GAME_DUMPER_CRC_EN
          crc_idx_next   = '0;
`endif
          state_next     = (prg_banks > MAX_PRG_BANKS) ? ST_ERROR : ST_HDR;
        end
      end
      ST_HDR: begin
        if (bus.out_ready) begin
          hdr_idx_next = hdr_idx_reg + 4'd1;
          if (hdr_idx_reg == 4'(INES_HDR_LEN - 1)) begin
            if (prg_reg != 8'd0) begin
              state_next = ST_RD_REQ;
            end else if (chr_reg != 8'd0) begin
              chr_phase_next = 1'b1;
              addr_next      = CHR_BASE;
              cnt_next       = 22'(chr_reg) << CHR_BANK_SHIFT;
              state_next     = ST_RD_REQ;
            end else begin
              state_next = TAIL_STATE;
            end
          end
        end
      end
      ST_RD_REQ: begin
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.mem_ack) begin
          data_next  = bus.mem_data;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          cnt_next  = cnt_reg - 22'd1;
          addr_next = addr_reg + ADDR_W'(1);
          if (cnt_reg == 22'd1) begin
            // PRG finished: move to CHR if there is any, otherwise wrap up.
            if (!chr_phase_reg && (chr_reg != 8'd0)) begin
              chr_phase_next = 1'b1;
              addr_next      = CHR_BASE;
              cnt_next       = 22'(chr_reg) << CHR_BANK_SHIFT;
              state_next     = ST_RD_REQ;
            end else begin
              state_next = TAIL_STATE;
            end
          end else begin
            state_next = ST_RD_REQ;
          end
        end
      end
`ifdef GAME_DUMPER_CRC_EN
      ST_CRC: begin
        if (bus.out_ready) begin
          crc_idx_next = crc_idx_reg + 2'd1;
          if (crc_idx_reg == 2'd3) begin
            state_next = ST_DONE;
          end
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output byte mux: header bytes, captured memory byte, or CRC trailer.
  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = 8'h00;
    case (state_reg)
      ST_HDR: begin
        out_valid_c = 1'b1;
        out_data_c  = ines_hdr_byte(hdr_idx_reg, prg_reg, chr_reg, mapper_reg, mirror_reg);
      end
      ST_SEND: begin
        out_valid_c = 1'b1;
        out_data_c  = data_reg;
      end
`ifdef GAME_DUMPER_CRC_EN
      ST_CRC: begin
        out_valid_c = 1'b1;
        case (crc_idx_reg)
          2'd0:    out_data_c = crc_final[7:0];
          2'd1:    out_data_c = crc_final[15:8];
          2'd2:    out_data_c = crc_final[23:16];
          default: out_data_c = crc_final[31:24];
        endcase
      end
`endif
      default: begin
        out_valid_c = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latched request, counters, address and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_idx_reg   <= '0;
      prg_reg       <= '0;
      chr_reg       <= '0;
      mapper_reg    <= '0;
      mirror_reg    <= 1'b0;
      chr_phase_reg <= 1'b0;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
`ifdef GAME_DUMPER_CRC_EN
      crc_idx_reg   <= '0;
`endif
    end else begin
      hdr_idx_reg   <= hdr_idx_next;
      prg_reg       <= prg_next;
      chr_reg       <= chr_next;
      mapper_reg    <= mapper_next;
      mirror_reg    <= mirror_next;
      chr_phase_reg <= chr_phase_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
`ifdef GAME_DUMPER_CRC_EN
      crc_idx_reg   <= crc_idx_next;
`endif
    end
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_rd    = (state_reg == ST_RD_REQ);
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign busy          = !(state_reg inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done          = (state_reg == ST_DONE);
  assign error         = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_game_dumper.sv
// Scoreboard bench for game_dumper: stimulus pushes the expected byte stream and
// read addresses; a monitor pops and compares whenever the DUT reads or emits.
module tb_game_dumper;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] prg_banks;
  logic [7:0] chr_banks;
  logic [7:0] mapper;
  logic       mirroring;
  logic       busy;
  logic       done;
  logic       error;

  game_dumper_if #(.ADDR_W(22)) bus ();

  game_dumper #(.ADDR_W(22), .CHR_BASE(22'h200000)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prg_banks (prg_banks),
    .chr_banks (chr_banks),
    .mapper    (mapper),
    .mirroring (mirroring),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [21:0] exp_addr_q[$];
  logic [7:0]  mem_seed;
  int          ack_delay;
  int          acc_cnt;

`ifdef GAME_DUMPER_CRC_EN
  localparam int TRAILER = 4;
`else
  localparam int TRAILER = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cartridge memory contents as a function of address.
  function automatic logic [7:0] mem_val(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ mem_seed;
  endfunction

  // Expected iNES stream and read addresses for one request.
  task automatic push_expect(input logic [7:0] p, input logic [7:0] c,
                             input logic [7:0] m, input logic mir);
    logic [31:0] crc;
    logic [7:0]  b;
    logic [21:0] a;
    if (p > 8'd128) return;
    exp_q.push_back(8'h4E); exp_q.push_back(8'h45);
    exp_q.push_back(8'h53); exp_q.push_back(8'h1A);
    exp_q.push_back(p);     exp_q.push_back(c);
    exp_q.push_back({m[3:0], 3'b000, mir});
    exp_q.push_back({m[7:4], 4'b0000});
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < int'(p) * 16384 + int'(c) * 8192; i++) begin
      a = (i < int'(p) * 16384) ? 22'(i) : 22'h200000 + 22'(i - int'(p) * 16384);
      b = mem_val(a);
      exp_addr_q.push_back(a);
      exp_q.push_back(b);
      crc = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    if (TRAILER == 4) begin
      exp_q.push_back(crc[7:0]);   exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[23:16]); exp_q.push_back(crc[31:24]);
    end
  endtask

  // Memory responder: one ack per read, ack_delay cycles after mem_rd.
  int          rsp_cnt;
  logic        rsp_pend;
  logic [21:0] rsp_addr;
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    rsp_pend     = 1'b0;
    rsp_cnt      = 0;
    rsp_addr     = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_val(rsp_addr);
          rsp_pend     = 1'b0;
        end
      end
      if (bus.mem_rd) begin
        rsp_pend = 1'b1;
        rsp_cnt  = ack_delay;
        rsp_addr = bus.mem_addr;
      end
    end
  end

  // Monitor: compares reads and accepted bytes against the scoreboard queues.
  logic        mon_stall;
  logic [7:0]  mon_data;
  logic [21:0] mon_addr;
  initial begin
    mon_stall = 1'b0;
    mon_data  = 8'h00;
    mon_addr  = '0;
    acc_cnt   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_stall = 1'b0;
      end else begin
        if (bus.mem_rd) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_rd_unexpected: got addr 0x%0h expected no read", bus.mem_addr);
          end else begin
            check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
          end
        end
        if (mon_stall && bus.out_valid) begin
          check("stall_data", 32'(bus.out_data), 32'(mon_data));
          check("stall_addr", 32'(bus.mem_addr), 32'(mon_addr));
        end
        if (bus.out_valid && bus.out_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_extra: got byte 0x%0h expected no byte", bus.out_data);
          end else begin
            check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
        end
        mon_stall = bus.out_valid && !bus.out_ready;
        mon_data  = bus.out_data;
        mon_addr  = bus.mem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue a one-cycle start, then scramble the inputs to prove they were latched.
  task automatic start_txn(input logic [7:0] p, input logic [7:0] c,
                           input logic [7:0] m, input logic mir);
    push_expect(p, c, m, mir);
    prg_banks = p; chr_banks = c; mapper = m; mirroring = mir;
    start = 1'b1;
    step();
    start     = 1'b0;
    prg_banks = 8'($urandom);
    chr_banks = 8'($urandom);
    mapper    = 8'($urandom);
    mirroring = 1'($urandom);
    $display("txn start prg=%0d chr=%0d mapper=0x%0h mirroring=%0d", p, c, m, mir);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!done && !error && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL timeout: got no done after %0d cycles expected done", budget);
    end
  endtask

  task automatic wait_reads(input int target, input int budget);
    int rd;
    int n;
    rd = 0;
    n  = 0;
    while (n < budget) begin
      if (bus.mem_rd) rd++;
      if (rd >= target) break;
      step();
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL read_wait: got %0d reads expected %0d", rd, target);
    end
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] m;
    logic       mir;
    reset = 1'b1; start = 1'b0;
    prg_banks = '0; chr_banks = '0; mapper = '0; mirroring = 1'b0;
    bus.out_ready = 1'b1;
    ack_delay = 1;
    mem_seed  = 8'($urandom);
    repeat (3) step();
    check("rst_flags", {27'd0, busy, done, error, bus.out_valid, bus.mem_rd}, 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    step();

    // Header-only streams with random mapper bits; one has a start pulse mid-stream.
    for (int t = 0; t < 4; t++) begin
      m = 8'($urandom); mir = 1'($urandom);
      base = acc_cnt;
      start_txn(8'd0, 8'd0, m, mir);
      check("start_busy", 32'(busy), 32'd1);
      check("start_first", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h4E});
      if (t == 1) begin
        step(); step();
        prg_banks = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
      end
      wait_end(200);
      check("hdr_done", {30'd0, done, busy}, 32'd2);
      check("hdr_len", 32'(acc_cnt - base), 32'(16 + TRAILER));
      step();
    end

    // Oversized PRG request: error, no reads, no bytes; a good start clears it.
    base = acc_cnt;
    start_txn(8'($urandom_range(129, 255)), 8'($urandom), 8'($urandom), 1'b1);
    check("err_flags", {29'd0, error, busy, bus.out_valid}, 32'd4);
    repeat (10) step();
    check("err_held", {30'd0, error, busy}, 32'd2);
    check("err_no_bytes", 32'(acc_cnt - base), 32'd0);
    start_txn(8'd0, 8'd0, 8'h5A, 1'b0);
    check("err_clear", {30'd0, error, busy}, 32'd1);
    wait_end(200);
    check("err_then_done", 32'(done), 32'd1);
    step();

    // Reset while waiting on a slow read; the late ack must be ignored.
    ack_delay = 3;
    start_txn(8'd2, 8'd0, 8'h42, 1'b0);
    wait_reads(5, 500);
    step();
    reset = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    step();
    check("abort_flags", {27'd0, busy, done, error, bus.out_valid, bus.mem_rd}, 32'd0);
    check("abort_data", 32'(bus.out_data), 32'd0);
    check("abort_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_quiet", {27'd0, busy, done, error, bus.out_valid, bus.mem_rd}, 32'd0);
    end
    ack_delay = 1;

    // Full PRG+CHR stream with a 5-cycle backpressure stall at PRG byte 100.
    m = 8'($urandom); mir = 1'($urandom);
    base = acc_cnt;
    start_txn(8'd1, 8'd1, m, mir);
    wait_reads(101, 2000);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_addr", 32'(bus.mem_addr), 32'd100);
    repeat (5) step();
    check("bp_no_read", {31'd0, bus.mem_rd}, 32'd0);
    check("bp_count", 32'(acc_cnt - base), 32'd116);
    bus.out_ready = 1'b1;
    wait_end(80000);
    check("full_done", {30'd0, done, busy}, 32'd2);
    check("full_len", 32'(acc_cnt - base), 32'(24592 + TRAILER));
    check("full_q_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
